// File: rtl/osc_pkg.sv
// Shared oscilloscope types: sample width, capture FSM states, slope codes.
// Used by the trigger/capture stage and its capture RAM.
package osc_pkg;

  localparam int DW = 12;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT,
    POST,
    READ
  } state_e;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

endpackage

// File: rtl/cap_ram.sv
// Capture window memory: one write port, one registered read port.
// Read data register resets to zero so the readout port is clean after reset.
module cap_ram #(
  parameter int DW = 12,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/trig_capture.sv
// Hysteresis trigger with pre/post ring-buffer capture and valid/ready readout.
// Optional AUTO_TRIG_EN: force a trigger after TIMEOUT cycles in WAIT.
module trig_capture
  import osc_pkg::*;
#(
  parameter int DW      = osc_pkg::DW,
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int HYST    = 16,
  parameter int TIMEOUT = 1000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_valid,
  input  logic [DW-1:0] data_in,
  input  logic [DW-1:0] level,
  input  logic          slope_sel,
  input  logic          arm,
  input  logic [AW-1:0] pretrig,
  output logic          busy,
  output logic          triggered,
  output logic          done,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  input  logic          rd_ready
);

  localparam logic [DW-1:0] MAXV   = '1;
  localparam logic [DW-1:0] HV     = DW'(HYST);
  localparam logic [AW:0]   DEPTHV = (AW+1)'(DEPTH);

  state_e        state_q;
  logic          slope_q;
  logic [DW-1:0] level_q;
  logic [AW-1:0] pre_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] trig_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   fcnt_q;
  logic          seen_lo_q;
  logic          seen_hi_q;
  logic          busy_q;
  logic          trig_q;
  logic          done_q;
  logic          rd_valid_q;
  logic          rd_last_q;

  logic [DW-1:0] lo;
  logic [DW-1:0] hi;
  logic [AW:0]   post_n;
  logic          real_hit;
  logic          forced;
  logic          hit;
  logic          we;
  logic          re;
  logic          xfer;

  assign lo = (level_q < HV) ? '0 : level_q - HV;
  assign hi = (level_q > MAXV - HV) ? MAXV : level_q + HV;

  assign real_hit =
    ((slope_q == SLOPE_RISE) && seen_lo_q && (data_in >= level_q)) ||
    ((slope_q == SLOPE_FALL) && seen_hi_q && (data_in <= level_q));
  assign hit = real_hit || forced;

  assign post_n = DEPTHV - {1'b0, pre_q};

  assign we = sample_valid &&
              ((state_q == PRE) || (state_q == WAIT) || (state_q == POST));
  assign re = (state_q == READ) && (fcnt_q != DEPTHV) &&
              (!rd_valid_q || rd_ready);
  assign xfer = rd_valid_q && rd_ready;

`ifdef AUTO_TRIG_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_q;

  assign forced = (to_q == TW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                to_q <= '0;
    else if (state_q != WAIT)  to_q <= '0;
    else if (!forced)          to_q <= to_q + 1'b1;
  end
`else
  // no timeout counter: WAIT holds until a real trigger
  assign forced = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      slope_q    <= 1'b0;
      level_q    <= '0;
      pre_q      <= '0;
      wr_ptr_q   <= '0;
      trig_ptr_q <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      fcnt_q     <= '0;
      seen_lo_q  <= 1'b0;
      seen_hi_q  <= 1'b0;
      busy_q     <= 1'b0;
      trig_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm) begin
            slope_q   <= slope_sel;
            level_q   <= level;
            pre_q     <= pretrig;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            seen_lo_q <= 1'b0;
            seen_hi_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= (pretrig == '0) ? WAIT : PRE;
          end
        end
        PRE: begin
          if (sample_valid) begin
            wr_ptr_q  <= wr_ptr_q + 1'b1;
            cnt_q     <= cnt_q + 1'b1;
            seen_lo_q <= seen_lo_q | (data_in < lo);
            seen_hi_q <= seen_hi_q | (data_in > hi);
            if (cnt_q + 1'b1 == {1'b0, pre_q}) state_q <= WAIT;
          end
        end
        WAIT: begin
          if (sample_valid) begin
            wr_ptr_q  <= wr_ptr_q + 1'b1;
            seen_lo_q <= seen_lo_q | (data_in < lo);
            seen_hi_q <= seen_hi_q | (data_in > hi);
            if (hit) begin
              trig_ptr_q <= wr_ptr_q;
              trig_q     <= real_hit;
              cnt_q      <= {{AW{1'b0}}, 1'b1};
              if (post_n == {{AW{1'b0}}, 1'b1}) begin
                state_q  <= READ;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                rd_ptr_q <= wr_ptr_q - pre_q;
                fcnt_q   <= '0;
              end else begin
                state_q <= POST;
              end
            end
          end
        end
        POST: begin
          if (sample_valid) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q + 1'b1 == post_n) begin
              state_q  <= READ;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              rd_ptr_q <= trig_ptr_q - pre_q;
              fcnt_q   <= '0;
            end
          end
        end
        READ: begin
          if (xfer && rd_last_q) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            trig_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
          end else if (re) begin
            rd_ptr_q   <= rd_ptr_q + 1'b1;
            fcnt_q     <= fcnt_q + 1'b1;
            rd_valid_q <= 1'b1;
            rd_last_q  <= (fcnt_q == DEPTHV - 1'b1);
          end else if (xfer) begin
            rd_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  cap_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .re_i    (re),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign busy      = busy_q;
  assign triggered = trig_q;
  assign done      = done_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;

endmodule

// File: tb/tb_trig_capture.sv
// Directed bench for trig_capture with DEPTH=16 and a short auto-trigger timeout.
// Inputs change on the falling edge; outputs are checked before the next rise.
module tb_trig_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] data_in = '0;
  logic [11:0] level = '0;
  logic        slope_sel = 1'b0;
  logic        arm = 1'b0;
  logic [3:0]  pretrig = '0;
  logic        busy;
  logic        triggered;
  logic        done;
  logic        rd_valid;
  logic [11:0] rd_data;
  logic        rd_last;
  logic        rd_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int expw[16];

  always #5 clk = ~clk;

  trig_capture #(
    .DW      (12),
    .DEPTH   (16),
    .AW      (4),
    .HYST    (16),
    .TIMEOUT (100)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .data_in      (data_in),
    .level        (level),
    .slope_sel    (slope_sel),
    .arm          (arm),
    .pretrig      (pretrig),
    .busy         (busy),
    .triggered    (triggered),
    .done         (done),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .rd_ready     (rd_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_trig"}, triggered, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, rd_valid, 0);
    chk({tag, "_data"}, rd_data, 0);
    chk({tag, "_last"}, rd_last, 0);
  endtask

  task automatic push(input int v);
    sample_valid = 1'b1;
    data_in = 12'(v);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic do_arm(input int lvl, input logic slp, input int pt);
    level = 12'(lvl);
    slope_sel = slp;
    pretrig = 4'(pt);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic read_win(input bit bp);
    int idx = 0;
    int cyc = 0;
    bit started = 1'b0;
    logic [3:0] pat = 4'b1001;
    while (idx < 16 && cyc < 100) begin
      rd_ready = bp ? pat[cyc % 4] : 1'b1;
      #1;
      if (rd_valid) begin
        if (!started) chk("first_lat_ok", (cyc <= 2), 1);
        started = 1'b1;
        if (rd_ready) begin
          chk("rd_data", rd_data, expw[idx]);
          chk("rd_last", rd_last, (idx == 15));
          idx++;
        end else begin
          chk("stall_data", rd_data, expw[idx]);
        end
      end else if (started) begin
        chk("bubble", rd_valid, 1);
      end
      @(negedge clk);
      cyc++;
    end
    rd_ready = 1'b0;
    chk("xfers", idx, 16);
    chk("done_clr", done, 0);
    chk("valid_clr", rd_valid, 0);
    chk("trig_clr", triggered, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    outs_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    outs_zero("idle");

    // abort a capture in POST with reset
    do_arm(2048, 1'b0, 4);
    chk("arm_busy", busy, 1);
    for (int k = 0; k < 5; k++) push(2000 + 10 * k);
    chk("pre_trig0", triggered, 0);
    push(2050);
    chk("mid_trig", triggered, 1);
    push(2060);
    rst_n = 1'b0;
    #1;
    outs_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    outs_zero("after_rst");

    // rising ramp, pretrig 4
    do_arm(2048, 1'b0, 4);
    for (int k = 0; k < 5; k++) push(2000 + 10 * k);
    chk("ramp_trig0", triggered, 0);
    push(2050);
    chk("ramp_trig1", triggered, 1);
    for (int k = 6; k < 17; k++) push(2000 + 10 * k);
    chk("ramp_done", done, 1);
    chk("ramp_busy", busy, 0);
    for (int i = 0; i < 16; i++) expw[i] = 2010 + 10 * i;
    read_win(1'b0);

    // hysteresis: small noise never re-arms
    do_arm(2048, 1'b0, 2);
    push(2040);
    push(2056);
    for (int k = 0; k < 5; k++) begin
      push(2040);
      push(2056);
    end
    chk("hyst_noise_trig", triggered, 0);
    chk("hyst_noise_busy", busy, 1);
    push(2000);
    chk("hyst_low_trig", triggered, 0);
    push(2060);
    chk("hyst_trig", triggered, 1);
    for (int k = 1; k <= 13; k++) push(2060 + k);
    chk("hyst_done", done, 1);
    expw[0] = 2056;
    expw[1] = 2000;
    for (int i = 2; i < 16; i++) expw[i] = 2060 + (i - 2);
    read_win(1'b0);

    // falling, level 0, pretrig 0, with backpressure
    do_arm(0, 1'b1, 0);
    push(100);
    do_arm(4000, 1'b0, 9);
    push(50);
    chk("fall_trig0", triggered, 0);
    push(0);
    chk("fall_trig1", triggered, 1);
    for (int k = 1; k < 16; k++) push(k);
    chk("fall_done", done, 1);
    for (int i = 0; i < 16; i++) expw[i] = i;
    read_win(1'b1);

`ifdef AUTO_TRIG_EN
    begin
      int n = 0;
      do_arm(1234, 1'b0, 4);
      while (!done && n < 300) begin
        push(1234);
        n++;
      end
      chk("auto_pushes", n, 116);
      chk("auto_done", done, 1);
      chk("auto_trig", triggered, 0);
      for (int i = 0; i < 16; i++) expw[i] = 1234;
      read_win(1'b0);
    end
`else
    do_arm(1234, 1'b0, 4);
    for (int k = 0; k < 150; k++) push(1234);
    chk("flat_busy", busy, 1);
    chk("flat_trig", triggered, 0);
    chk("flat_done", done, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    outs_zero("flat_rst");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
